// File: rtl/dma_icb_arbiter.sv
// Two-requester ICB arbiter: round-robin command grant onto one DMA master port,
// with an in-order ID FIFO that steers each response back to its issuer.

module dma_icb_arbiter_idfifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head,
    output logic empty,
    output logic full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Storage is rounded up to 2**PW so a depth of 1 still has a legal index.
    logic [(1 << PW)-1:0] ids;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;

    assign head  = ids[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ids    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                ids[wr_ptr] <= push_id;
                wr_ptr      <= (DEPTH == 1) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (DEPTH == 1) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module dma_icb_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_icb_cmd_valid,
    output logic            m0_icb_cmd_ready,
    input  logic            m0_icb_cmd_read,
    input  logic [AW-1:0]   m0_icb_cmd_addr,
    input  logic [DW-1:0]   m0_icb_cmd_wdata,
    input  logic [DW/8-1:0] m0_icb_cmd_wmask,
    output logic            m0_icb_rsp_valid,
    input  logic            m0_icb_rsp_ready,
    output logic [DW-1:0]   m0_icb_rsp_rdata,
    output logic            m0_icb_rsp_err,

    input  logic            m1_icb_cmd_valid,
    output logic            m1_icb_cmd_ready,
    input  logic            m1_icb_cmd_read,
    input  logic [AW-1:0]   m1_icb_cmd_addr,
    input  logic [DW-1:0]   m1_icb_cmd_wdata,
    input  logic [DW/8-1:0] m1_icb_cmd_wmask,
    output logic            m1_icb_rsp_valid,
    input  logic            m1_icb_rsp_ready,
    output logic [DW-1:0]   m1_icb_rsp_rdata,
    output logic            m1_icb_rsp_err,

    output logic            dma_icb_cmd_valid,
    input  logic            dma_icb_cmd_ready,
    output logic            dma_icb_cmd_read,
    output logic [AW-1:0]   dma_icb_cmd_addr,
    output logic [DW-1:0]   dma_icb_cmd_wdata,
    output logic [DW/8-1:0] dma_icb_cmd_wmask,
    input  logic            dma_icb_rsp_valid,
    output logic            dma_icb_rsp_ready,
    input  logic [DW-1:0]   dma_icb_rsp_rdata,
    input  logic            dma_icb_rsp_err,

    output logic            arb_busy
);
    logic lock;
    logic lock_id;
    logic rr_ptr;
    logic sel;
    logic full;
    logic empty;
    logic head;
    logic cmd_hs;
    logic rsp_hs;

    // A presented-but-stalled command holds the grant until it handshakes.
    always_comb begin
        sel = 1'b0;
        if (lock)
            sel = lock_id;
        else if (m0_icb_cmd_valid && m1_icb_cmd_valid)
            sel = rr_ptr;
        else if (m1_icb_cmd_valid)
            sel = 1'b1;
    end

    assign dma_icb_cmd_valid = (sel ? m1_icb_cmd_valid : m0_icb_cmd_valid) & ~full;
    assign dma_icb_cmd_read  = sel ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign dma_icb_cmd_addr  = sel ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign dma_icb_cmd_wdata = sel ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign dma_icb_cmd_wmask = sel ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

    assign m0_icb_cmd_ready = ~sel & dma_icb_cmd_ready & ~full;
    assign m1_icb_cmd_ready =  sel & dma_icb_cmd_ready & ~full;

    assign cmd_hs = dma_icb_cmd_valid & dma_icb_cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock    <= 1'b0;
            lock_id <= 1'b0;
            rr_ptr  <= 1'b0;
        end else begin
            if (cmd_hs) begin
                lock   <= 1'b0;
                rr_ptr <= ~sel;
            end else if (dma_icb_cmd_valid) begin
                lock    <= 1'b1;
                lock_id <= sel;
            end
        end
    end

    dma_icb_arbiter_idfifo #(
        .DEPTH (OUTS_DEPTH)
    ) u_idfifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cmd_hs),
        .push_id (sel),
        .pop     (rsp_hs),
        .head    (head),
        .empty   (empty),
        .full    (full)
    );

    // Only the FIFO head's owner sees the response; an unsolicited one is stalled.
    assign m0_icb_rsp_valid  = dma_icb_rsp_valid & ~empty & ~head;
    assign m1_icb_rsp_valid  = dma_icb_rsp_valid & ~empty &  head;
    assign dma_icb_rsp_ready = ~empty & (head ? m1_icb_rsp_ready : m0_icb_rsp_ready);
    assign rsp_hs            = dma_icb_rsp_valid & dma_icb_rsp_ready;

    assign m0_icb_rsp_rdata = dma_icb_rsp_rdata;
    assign m1_icb_rsp_rdata = dma_icb_rsp_rdata;
    assign m0_icb_rsp_err   = dma_icb_rsp_err;
    assign m1_icb_rsp_err   = dma_icb_rsp_err;

    assign arb_busy = m0_icb_cmd_valid | m1_icb_cmd_valid | ~empty;
endmodule

// File: tb/tb_dma_icb_arbiter.sv
// Directed bench for dma_icb_arbiter: inputs driven at negedge, outputs checked #1 later.

module tb_dma_icb_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
    logic [AW-1:0]   m0_icb_cmd_addr;
    logic [DW-1:0]   m0_icb_cmd_wdata;
    logic [DW/8-1:0] m0_icb_cmd_wmask;
    logic            m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
    logic [DW-1:0]   m0_icb_rsp_rdata;
    logic            m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
    logic [AW-1:0]   m1_icb_cmd_addr;
    logic [DW-1:0]   m1_icb_cmd_wdata;
    logic [DW/8-1:0] m1_icb_cmd_wmask;
    logic            m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
    logic [DW-1:0]   m1_icb_rsp_rdata;
    logic            dma_icb_cmd_valid, dma_icb_cmd_ready, dma_icb_cmd_read;
    logic [AW-1:0]   dma_icb_cmd_addr;
    logic [DW-1:0]   dma_icb_cmd_wdata;
    logic [DW/8-1:0] dma_icb_cmd_wmask;
    logic            dma_icb_rsp_valid, dma_icb_rsp_ready, dma_icb_rsp_err;
    logic [DW-1:0]   dma_icb_rsp_rdata;
    logic            arb_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dma_icb_arbiter #(.AW(AW), .DW(DW), .OUTS_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
        .m0_icb_cmd_read(m0_icb_cmd_read), .m0_icb_cmd_addr(m0_icb_cmd_addr),
        .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
        .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
        .m0_icb_rsp_rdata(m0_icb_rsp_rdata), .m0_icb_rsp_err(m0_icb_rsp_err),
        .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
        .m1_icb_cmd_read(m1_icb_cmd_read), .m1_icb_cmd_addr(m1_icb_cmd_addr),
        .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
        .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
        .m1_icb_rsp_rdata(m1_icb_rsp_rdata), .m1_icb_rsp_err(m1_icb_rsp_err),
        .dma_icb_cmd_valid(dma_icb_cmd_valid), .dma_icb_cmd_ready(dma_icb_cmd_ready),
        .dma_icb_cmd_read(dma_icb_cmd_read), .dma_icb_cmd_addr(dma_icb_cmd_addr),
        .dma_icb_cmd_wdata(dma_icb_cmd_wdata), .dma_icb_cmd_wmask(dma_icb_cmd_wmask),
        .dma_icb_rsp_valid(dma_icb_rsp_valid), .dma_icb_rsp_ready(dma_icb_rsp_ready),
        .dma_icb_rsp_rdata(dma_icb_rsp_rdata), .dma_icb_rsp_err(dma_icb_rsp_err),
        .arb_busy(arb_busy)
    );

    task automatic idle_inputs();
        m0_icb_cmd_valid = 0; m0_icb_cmd_read = 0; m0_icb_cmd_addr = '0;
        m0_icb_cmd_wdata = '0; m0_icb_cmd_wmask = '0; m0_icb_rsp_ready = 0;
        m1_icb_cmd_valid = 0; m1_icb_cmd_read = 0; m1_icb_cmd_addr = '0;
        m1_icb_cmd_wdata = '0; m1_icb_cmd_wmask = '0; m1_icb_rsp_ready = 0;
        dma_icb_cmd_ready = 0; dma_icb_rsp_valid = 0; dma_icb_rsp_rdata = '0;
        dma_icb_rsp_err = 0;
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        rst_n = 0;
        idle_inputs();
        #12;
        outs = {m0_icb_cmd_ready, m1_icb_cmd_ready, m0_icb_rsp_valid, m1_icb_rsp_valid,
                dma_icb_cmd_valid, dma_icb_rsp_ready, arb_busy};
        checks++;
        if (outs !== 7'b0) begin errors++; $display("FAIL reset_outputs: got %b exp 0000000", outs); end
        @(negedge clk); rst_n = 1;
    endtask

    // Both requesters valid every cycle: grants alternate from m0; each response lands a cycle later.
    task automatic test_contention();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m0_icb_cmd_valid = (i < 4); m0_icb_cmd_addr = 32'h0000_0100;
            m1_icb_cmd_valid = (i < 4); m1_icb_cmd_addr = 32'h0000_0200;
            dma_icb_cmd_ready = 1; m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
            dma_icb_rsp_valid = (i > 0); dma_icb_rsp_rdata = i;
            #1;
            if (i < 4) begin
                checks++;
                if (dma_icb_cmd_addr !== ((i % 2 == 0) ? 32'h100 : 32'h200) ||
                    m0_icb_cmd_ready !== (i % 2 == 0) || m1_icb_cmd_ready !== (i % 2 == 1)) begin
                    errors++;
                    $display("FAIL contention_grant[%0d]: got addr=%h r0=%b r1=%b exp owner m%0d",
                             i, dma_icb_cmd_addr, m0_icb_cmd_ready, m1_icb_cmd_ready, i % 2);
                end
            end
            if (i > 0) begin
                checks++;
                if (m0_icb_rsp_valid !== ((i - 1) % 2 == 0) || m1_icb_rsp_valid !== ((i - 1) % 2 == 1)) begin
                    errors++;
                    $display("FAIL contention_rsp[%0d]: got v0=%b v1=%b exp owner m%0d",
                             i, m0_icb_rsp_valid, m1_icb_rsp_valid, (i - 1) % 2);
                end
            end
        end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_single();
        @(negedge clk);
        m0_icb_cmd_valid = 1; m0_icb_cmd_read = 1; m0_icb_cmd_addr = 32'h1000_0000;
        dma_icb_cmd_ready = 1;
        #1;
        checks++;
        if (dma_icb_cmd_valid !== 1 || dma_icb_cmd_read !== 1 || dma_icb_cmd_addr !== 32'h1000_0000 ||
            m0_icb_cmd_ready !== 1 || m1_icb_cmd_ready !== 0) begin
            errors++;
            $display("FAIL single_cmd: got v=%b rd=%b addr=%h r0=%b r1=%b exp 1 1 10000000 1 0",
                     dma_icb_cmd_valid, dma_icb_cmd_read, dma_icb_cmd_addr, m0_icb_cmd_ready, m1_icb_cmd_ready);
        end
        @(negedge clk);
        idle_inputs();
        dma_icb_rsp_valid = 1; dma_icb_rsp_rdata = 32'hA5A5_A5A5; m0_icb_rsp_ready = 1;
        #1;
        checks++;
        if (m0_icb_rsp_valid !== 1 || m1_icb_rsp_valid !== 0 || m0_icb_rsp_rdata !== 32'hA5A5_A5A5 ||
            dma_icb_rsp_ready !== 1) begin
            errors++;
            $display("FAIL single_rsp: got v0=%b v1=%b data=%h rdy=%b exp 1 0 a5a5a5a5 1",
                     m0_icb_rsp_valid, m1_icb_rsp_valid, m0_icb_rsp_rdata, dma_icb_rsp_ready);
        end
        @(negedge clk); idle_inputs(); #1;
        checks++;
        if (arb_busy !== 0) begin errors++; $display("FAIL single_idle_busy: got %b exp 0", arb_busy); end
    endtask

    // rr_ptr points at m1 here, so only the lock keeps m0 granted once m1 rises.
    task automatic test_lock();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'hAAAA_0000;
            m1_icb_cmd_valid = (i >= 1); m1_icb_cmd_addr = 32'hBBBB_0000;
            dma_icb_cmd_ready = (i == 3);
            #1;
            checks++;
            if (dma_icb_cmd_valid !== 1 || dma_icb_cmd_addr !== 32'hAAAA_0000 ||
                m0_icb_cmd_ready !== (i == 3) || m1_icb_cmd_ready !== 0) begin
                errors++;
                $display("FAIL lock_hold[%0d]: got v=%b addr=%h r0=%b r1=%b exp 1 aaaa0000 %b 0",
                         i, dma_icb_cmd_valid, dma_icb_cmd_addr, m0_icb_cmd_ready, m1_icb_cmd_ready, i == 3);
            end
        end
        @(negedge clk);
        m0_icb_cmd_valid = 0;
        #1;
        checks++;
        if (dma_icb_cmd_addr !== 32'hBBBB_0000 || m1_icb_cmd_ready !== 1) begin
            errors++;
            $display("FAIL lock_next_m1: got addr=%h r1=%b exp bbbb0000 1", dma_icb_cmd_addr, m1_icb_cmd_ready);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle_inputs();
            dma_icb_rsp_valid = 1; m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
            #1;
            checks++;
            if (m0_icb_rsp_valid !== (i == 0) || m1_icb_rsp_valid !== (i == 1)) begin
                errors++;
                $display("FAIL lock_rsp[%0d]: got v0=%b v1=%b exp owner m%0d", i, m0_icb_rsp_valid, m1_icb_rsp_valid, i);
            end
        end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h1000 + 4 * ((i < 2) ? i : 2);
            dma_icb_cmd_ready = 1; m0_icb_rsp_ready = 1;
            dma_icb_rsp_valid = (i == 3);
            #1;
            checks++;
            if (dma_icb_cmd_valid !== (i != 2 && i != 3) || m0_icb_cmd_ready !== (i != 2 && i != 3)) begin
                errors++;
                $display("FAIL full_block[%0d]: got v=%b r0=%b exp %b", i, dma_icb_cmd_valid,
                         m0_icb_cmd_ready, (i != 2 && i != 3));
            end
        end
        m0_icb_cmd_valid = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle_inputs(); dma_icb_rsp_valid = 1; m0_icb_rsp_ready = 1;
        end
        @(negedge clk); idle_inputs(); #1;
        checks++;
        if (arb_busy !== 0) begin errors++; $display("FAIL full_drained_busy: got %b exp 0", arb_busy); end
    endtask

    task automatic test_err_backpressure();
        @(negedge clk);
        m1_icb_cmd_valid = 1; dma_icb_cmd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            dma_icb_rsp_valid = 1; dma_icb_rsp_err = 1; m1_icb_rsp_ready = (i == 2); m0_icb_rsp_ready = 1;
            #1;
            checks++;
            if (i < 3) begin
                if (dma_icb_rsp_ready !== (i == 2) || m1_icb_rsp_valid !== 1 || m0_icb_rsp_valid !== 0 ||
                    m1_icb_rsp_err !== 1) begin
                    errors++;
                    $display("FAIL err_bp[%0d]: got rdy=%b v1=%b v0=%b err=%b exp %b 1 0 1", i,
                             dma_icb_rsp_ready, m1_icb_rsp_valid, m0_icb_rsp_valid, m1_icb_rsp_err, i == 2);
                end
            end else begin
                if (dma_icb_rsp_ready !== 0 || m0_icb_rsp_valid !== 0 || m1_icb_rsp_valid !== 0 || arb_busy !== 0) begin
                    errors++;
                    $display("FAIL unsolicited_rsp: got rdy=%b v0=%b v1=%b busy=%b exp 0 0 0 0",
                             dma_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid, arb_busy);
                end
            end
        end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        m1_icb_cmd_valid = 1; dma_icb_cmd_ready = 1;
        @(negedge clk);
        m1_icb_cmd_valid = 0; m0_icb_cmd_valid = 1;
        @(negedge clk);
        idle_inputs();
        dma_icb_rsp_valid = 1; m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
        #1;
        checks++;
        if (arb_busy !== 1) begin errors++; $display("FAIL midflight_busy: got %b exp 1", arb_busy); end
        #1 rst_n = 0;
        #1;
        checks++;
        if (arb_busy !== 0 || dma_icb_rsp_ready !== 0 || m0_icb_rsp_valid !== 0 || m1_icb_rsp_valid !== 0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b rdy=%b v0=%b v1=%b exp 0 0 0 0",
                     arb_busy, dma_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid);
        end
        @(negedge clk); idle_inputs(); rst_n = 1;
        @(negedge clk); #1;
        checks++;
        if (arb_busy !== 0) begin errors++; $display("FAIL post_reset_busy: got %b exp 0", arb_busy); end
        @(negedge clk);
        m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h0000_00A0;
        m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h0000_00B0;
        #1;
        checks++;
        if (dma_icb_cmd_addr !== 32'h0000_00A0) begin
            errors++;
            $display("FAIL post_reset_rr: got addr=%h exp 000000a0", dma_icb_cmd_addr);
        end
        @(negedge clk); idle_inputs();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_lock();
        test_full();
        test_err_backpressure();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
